// File: rtl/tensor_requant_pkg.sv
// ----------------------------------------------------------------------------
// tensor_requant_pkg
//   Shared widths, saturation limits and datatypes for the accumulator
//   drain / requantize stage (tensor_acc_requant and its requant_lane).
//   Optional feature macro used by this slice: TENSOR_REQUANT_RELU_EN.
// ----------------------------------------------------------------------------
package tensor_requant_pkg;

  localparam int ACC_WIDTH = 32;            // accumulator width, signed
  localparam int OUT_WIDTH = 8;             // per-lane result width, signed
  localparam int LANES     = 3;             // accumulator lanes
  localparam int SHIFT_W   = 5;             // right-shift amount width (0..31)
  localparam int RS_WIDTH  = ACC_WIDTH + 1; // round+shift headroom, never wraps
  localparam int SAT_MAX   = 127;
  localparam int SAT_MIN   = -128;

  typedef logic signed [OUT_WIDTH-1:0] lane_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic signed [RS_WIDTH-1:0]  rs_t;

endpackage

// File: rtl/requant_lane.sv
// ----------------------------------------------------------------------------
// requant_lane
//   Combinational arithmetic for one accumulator lane. The two halves sit on
//   either side of the S2 pipeline register held in the parent:
//     acc_in/shift_amt -> rs_out   : round-half-up, arithmetic right shift
//     rs_in            -> lane_out : optional ReLU, saturate to int8
//   Ports:
//     acc_in    in  acc_t   S1-registered accumulator
//     shift_amt in  5       S1-registered shift amount
//     rs_out    out rs_t    rounded/shifted value (33b) for the S2 register
//     rs_in     in  rs_t    S2-registered rounded/shifted value
//     lane_out  out lane_t  saturated int8 result
//   Macro: TENSOR_REQUANT_RELU_EN clamps negative results to 0 before
//   saturation; when undefined no ReLU logic exists.
// ----------------------------------------------------------------------------
module requant_lane
  import tensor_requant_pkg::*;
(
  input  acc_t               acc_in,
  input  logic [SHIFT_W-1:0] shift_amt,
  output rs_t                rs_out,
  input  rs_t                rs_in,
  output lane_t              lane_out
);

  // Sign-extend by one bit so adding the half-LSB bias can never wrap.
  function automatic rs_t round_shift(input acc_t acc, input logic [SHIFT_W-1:0] sh);
    rs_t ext;
    rs_t bias;
    ext  = rs_t'(acc);
    bias = '0;
    if (sh != '0) bias = rs_t'(1) <<< (sh - SHIFT_W'(1));
    return (ext + bias) >>> sh;
  endfunction

  function automatic lane_t saturate(input rs_t v);
    lane_t r;
    if (v > rs_t'(SAT_MAX))      r = lane_t'(SAT_MAX);
    else if (v < rs_t'(SAT_MIN)) r = lane_t'(SAT_MIN);
    else                         r = lane_t'(v);
    return r;
  endfunction

`ifdef TENSOR_REQUANT_RELU_EN
  function automatic rs_t relu(input rs_t v);
    return v[RS_WIDTH-1] ? '0 : v;
  endfunction
`endif

  always_comb begin
    rs_out = round_shift(acc_in, shift_amt);
`ifdef TENSOR_REQUANT_RELU_EN
    lane_out = saturate(relu(rs_in));
`else
    lane_out = saturate(rs_in);
`endif
  end

endmodule

// File: rtl/tensor_acc_requant.sv
// ----------------------------------------------------------------------------
// tensor_acc_requant
//   Drain/requantize stage behind the int8 tensor block. Captures three
//   32-bit accumulators on acc_valid, rounds/shifts/saturates each to int8,
//   packs {lane2,lane1,lane0} and buffers the word in a small FIFO with a
//   valid/ready output.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous, active-low
//     acc_valid  in   capture strobe for acc0_in..acc2_in / shift_amt
//     acc0_in..acc2_in in 32  lane accumulators
//     shift_amt  in   5   right-shift amount 0..31
//     in_ready   out  a capture this cycle is guaranteed a FIFO slot
//     out_data   out  24  {lane2,lane1,lane0}, holds last head when empty
//     out_valid  out  FIFO head valid
//     out_ready  in   consumer pop
//     fifo_count out  FIFO occupancy 0..FIFO_DEPTH
//     overflow   out  sticky, a capture was dropped at the FIFO
//   Macro: TENSOR_REQUANT_RELU_EN (see requant_lane).
// ----------------------------------------------------------------------------
module tensor_acc_requant
  import tensor_requant_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int WORD_W     = LANES * OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 acc_valid,
  input  logic [ACC_WIDTH-1:0] acc0_in,
  input  logic [ACC_WIDTH-1:0] acc1_in,
  input  logic [ACC_WIDTH-1:0] acc2_in,
  input  logic [SHIFT_W-1:0]   shift_amt,
  output logic                 in_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow
);

  acc_t acc_w [LANES];
  assign acc_w[0] = acc0_in;
  assign acc_w[1] = acc1_in;
  assign acc_w[2] = acc2_in;

  logic               vld_p0_q, vld_p0_d;
  acc_t               acc_p0_q [LANES];
  acc_t               acc_p0_d [LANES];
  logic [SHIFT_W-1:0] shift_p0_q, shift_p0_d;

  logic               vld_p1_q, vld_p1_d;
  rs_t                rs_w     [LANES];
  rs_t                rs_p1_q  [LANES];
  rs_t                rs_p1_d  [LANES];

  lane_t              sat_w    [LANES];
  logic [WORD_W-1:0]  wr_word;

  logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [WORD_W-1:0]  hold_q, hold_d;

  logic               head_vld, fifo_full, pop, push, drop;
  logic [CNT_W:0]     credits_used;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane u_lane (
      .acc_in    (acc_p0_q[g]),
      .shift_amt (shift_p0_q),
      .rs_out    (rs_w[g]),
      .rs_in     (rs_p1_q[g]),
      .lane_out  (sat_w[g])
    );
    assign wr_word[g*OUT_WIDTH +: OUT_WIDTH] = sat_w[g];
  end

  always_comb begin
    // S1: capture accumulators and shift amount on the strobe
    vld_p0_d   = acc_valid;
    acc_p0_d   = acc_p0_q;
    shift_p0_d = shift_p0_q;
    if (acc_valid) begin
      acc_p0_d   = acc_w;
      shift_p0_d = shift_amt;
    end
    // S2: register the rounded/shifted 33-bit lane values
    vld_p1_d = vld_p0_q;
    rs_p1_d  = rs_p1_q;
    if (vld_p0_q) rs_p1_d = rs_w;
  end

  // S3: saturated word is written into the FIFO. A full FIFO still accepts
  // the write when the head is popped in the same cycle.
  always_comb begin
    head_vld   = (count_q != '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = head_vld & out_ready;
    push       = vld_p1_q & (~fifo_full | pop);
    drop       = vld_p1_q & fifo_full & ~pop;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_word;

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q | drop;
    hold_d     = head_vld ? mem_q[rd_ptr_q] : hold_q;

    // Credits: every word already in the pipe owns a future FIFO slot.
    // A pop this cycle is deliberately not credited.
    credits_used = {1'b0, count_q} + (CNT_W+1)'(vld_p0_q) + (CNT_W+1)'(vld_p1_q);
  end

  assign in_ready   = (credits_used < (CNT_W+1)'(FIFO_DEPTH));
  assign out_valid  = head_vld;
  assign out_data   = head_vld ? mem_q[rd_ptr_q] : hold_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_p0_q   <= acc_p0_d;
    shift_p0_q <= shift_p0_d;
    rs_p1_q    <= rs_p1_d;
    mem_q      <= mem_d;
  end

endmodule
